// File: rtl/ifb_pkg.sv
// ifb_pkg: shared widths, entry types and PC helper for the instruction-fetch buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ifb_pkg;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 32;
  localparam int INST_BYTES = 4;

  // One queued instruction: the word and the byte address it was fetched from.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } ifb_entry_t;

  // One slot of the memory-latency pipe: a request is outstanding when valid is set.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] pc;
  } inflight_t;

  // Force a byte address onto an instruction boundary.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return pc & ~ADDR_W'(INST_BYTES - 1);
  endfunction

endpackage

// File: rtl/ifb_fifo.sv
// ifb_fifo: DEPTH-entry synchronous FIFO with flush; head output reads zero while empty.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: none internally; the caller guarantees no push when full (credit control upstream).
module ifb_fifo
  import ifb_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = ifb_entry_t
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  T                             i_push_dat,
  input  logic                         i_pop,
  output T                             o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_empty,
  output logic                         o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  // A pop against an empty queue is ignored rather than corrupting the pointers.
  assign w_pop   = i_pop && !o_empty;
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));

  // Pointer and occupancy update; flush drops everything but keeps the pointers aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents need no reset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (!rst && !i_flush && i_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  // Head presentation: zero when empty so no stale entry ever leaks out.
  always_comb begin
    o_head = '0;
    if (!o_empty) o_head = r_mem[r_rd_ptr];
  end

endmodule

// File: rtl/ifetch_buffer.sv
// ifetch_buffer: instruction prefetch queue between core fetch and the imem pads (IFB_BYPASS_EN adds empty-queue bypass).
// Latency: fetch-to-core LAT+1 cycles, or LAT with IFB_BYPASS_EN; redirect shows the new PC on im_address next cycle.
// Backpressure: issue stalls once queued plus in-flight words reach DEPTH; inst_ready never feeds inst_valid.
module ifetch_buffer
  import ifb_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                LAT      = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] im_address,
  input  logic [DATA_W-1:0] im_read_data
);

  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int LAT_CW = $clog2(LAT+1);
  localparam int OCC_W  = $clog2(DEPTH+LAT+1);

  logic [ADDR_W-1:0] r_fetch_pc;
  inflight_t         r_inflight [LAT];

  logic [LAT_CW-1:0] w_inflight_cnt;
  logic [OCC_W-1:0]  w_occupancy;
  logic              w_issue;
  logic              w_cap_vld;
  logic [ADDR_W-1:0] w_cap_pc;
  logic              w_bypass;
  logic              w_fifo_push;
  logic              w_fifo_pop;
  ifb_entry_t        w_push_dat;
  ifb_entry_t        w_head;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_fifo_empty;
  logic              w_fifo_full;

  assign im_address = r_fetch_pc;
  assign w_cap_vld  = r_inflight[LAT-1].valid;
  assign w_cap_pc   = r_inflight[LAT-1].pc;

  // Count outstanding memory requests; each one already owns a queue slot.
  always_comb begin
    w_inflight_cnt = '0;
    for (int i = 0; i < LAT; i++) begin
      w_inflight_cnt = w_inflight_cnt + LAT_CW'(r_inflight[i].valid);
    end
  end

  // Credit check uses the pre-pop count so a pop never lets an issue overbook the queue.
  always_comb begin
    w_occupancy = OCC_W'(w_fifo_count) + OCC_W'(w_inflight_cnt);
    w_issue     = !rst && !redirect_valid && !w_fifo_full &&
                  (w_occupancy < OCC_W'(DEPTH));
  end

  // Fetch PC: reset and redirect win over the sequential advance, which wraps at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetch_pc <= align_pc(redirect_pc);
    end else if (w_issue) begin
      r_fetch_pc <= r_fetch_pc + ADDR_W'(INST_BYTES);
    end
  end

  // In-flight pipe: one slot per cycle of memory latency; redirect kills every outstanding response.
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      for (int i = 0; i < LAT; i++) begin
        r_inflight[i] <= '0;
      end
    end else begin
      r_inflight[0] <= inflight_t'{valid: w_issue, pc: r_fetch_pc};
      for (int i = 1; i < LAT; i++) begin
        r_inflight[i] <= r_inflight[i-1];
      end
    end
  end

`ifdef IFB_BYPASS_EN
  // A response arriving at an empty queue is offered to the core in the same cycle.
  assign w_bypass = w_fifo_empty && w_cap_vld;
`else
  assign w_bypass = 1'b0;
`endif

  // Output mux and queue control: a bypassed word accepted by the core is never written.
  always_comb begin
    inst_valid  = !w_fifo_empty || w_bypass;
    inst_data   = w_head.data;
    inst_pc     = w_head.pc;
    if (w_bypass) begin
      inst_data = im_read_data;
      inst_pc   = w_cap_pc;
    end
    w_push_dat  = ifb_entry_t'{pc: w_cap_pc, data: im_read_data};
    w_fifo_push = w_cap_vld && !(w_bypass && inst_ready);
    w_fifo_pop  = !w_bypass && !w_fifo_empty && inst_ready && !redirect_valid;
  end

  ifb_fifo #(
    .DEPTH (DEPTH),
    .T     (ifb_entry_t)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (redirect_valid),
    .i_push     (w_fifo_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_fifo_pop),
    .o_head     (w_head),
    .o_count    (w_fifo_count),
    .o_empty    (w_fifo_empty),
    .o_full     (w_fifo_full)
  );

endmodule
